nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder that drives the existing four_bit_rca one nibble per clock, LSB nibble first.
//  Registers the inter-nibble carry between cycles.
//  Sits directly upstream of four_bit_rca: slices operands, feeds A/B/Cin, and consumes S/Cout.
//  Valid/ready handshakes on input and output.
// PARAMETERS
//  WIDTH    16   operand/sum width; must be a multiple of 4 and >= 4
//  NIBBLES  WIDTH/4   derived localparam; cycles per addition
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active low
//  in_valid   in   1      operands valid
//  in_ready   out  1      block idle, can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into LSB nibble
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB nibble
//  sub        in   1      subtract select; present only with NSA_SUB_MODE_EN
// BEHAVIOUR
//  - Reset (rst_n=0): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry reg=0, nibble count=0.
//  - States:
//    - IDLE: in_ready=1. On in_valid: latch a, b, cin into the operand shift regs and carry reg; count=0; go to ADD.
//    - ADD: in_ready=0. Each cycle the rca sees A=a_sh[3:0], B=b_sh[3:0], Cin=carry.
//      Its S shifts into sum_sh from the MSB end; carry<=Cout; a_sh/b_sh shift right by 4; count++.
//      When count==NIBBLES-1: go to DONE.
//    - DONE: out_valid=1; sum=sum_sh, cout=carry. On out_ready: go to IDLE.
//  - Latency: acceptance edge plus NIBBLES edges until out_valid=1 (WIDTH=16: 4 ADD cycles).
//  - out_valid is never combinational from in_valid.
//  - Backpressure:
//    - While out_valid=1 and out_ready=0, sum and cout hold stable.
//    - in_valid is ignored outside IDLE; no operand is lost or overwritten.
//  - Back-to-back operations: result handshake returns to IDLE; in_ready=1 on the following cycle (one bubble).
//  - Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. Plain unsigned; no saturation.
//  - Counter: $clog2(NIBBLES) bits, minimum 1; cleared on accept; never wraps past NIBBLES-1.
//  - Reset mid-operation aborts immediately. All state returns to reset values; the partial result is discarded.
// CONFIGURATION
//  NSA_SUB_MODE_EN defined:
//    - Adds port sub. When sub=1 at accept, b is latched as ~b and the carry reg as 1; cin is ignored.
//    - sum = a - b mod 2^WIDTH; cout=1 means no borrow.
//    - sub=0 behaves exactly as the undefined build.
//  NSA_SUB_MODE_EN undefined: no sub port; addition only.
// STRUCTURE
//  - Package nsa_pkg: state enum (IDLE=2'd0, ADD=2'd1, DONE=2'd2), NIBBLE_W=4.
//  - One sub-module: the existing four_bit_rca, single instance, ports A, B, Cin, S, Cout.
//  - FSM, count, shift regs and carry reg live in this module.
// TESTING (WIDTH=16)
//  1. a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept; sum=0x5555, cout=0.
//  2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all nibbles).
//  3. a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
//  4. out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0.
//     A new in_valid pulse is ignored; the next accept happens only after the handshake.
//  5. rst_n pulsed low during the 3rd ADD cycle -> out_valid=0, sum=0, cout=0 immediately.
//     in_ready=1 after release; the next operation is correct.
//  6. NSA_SUB_MODE_EN, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
//     a=0x0007, b=0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for nibble_serial_adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for a given nibble count; never narrower than one bit.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/four_bit_rca.sv
// Four-bit ripple-carry adder: a chain of four full adders.
module four_bit_rca (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] w_c;

    assign w_c[0] = Cin;

    // One full adder per bit; carry ripples from bit 0 upward.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one nibble per clock (LSB first)
// through a single four_bit_rca, registering the carry between nibbles.
// Valid/ready handshakes on both operand input and result output.
// Optional build macro NSA_SUB_MODE_EN adds a 'sub' port for a - b.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;
    logic [NIBBLE_W-1:0] w_rca_s;
    logic               w_rca_cout;
    logic [WIDTH-1:0]   w_sum_next;

    // Operand conditioning at accept: subtraction is a + ~b + 1.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_b_in   = b;
        w_cin_in = cin;
`ifdef NSA_SUB_MODE_EN
        if (sub) begin
            w_b_in   = ~b;
            w_cin_in = 1'b1;
        end
`endif
    end

    four_bit_rca u_rca (
        .A    (r_a_sh[NIBBLE_W-1:0]),
        .B    (r_b_sh[NIBBLE_W-1:0]),
        .Cin  (r_carry),
        .S    (w_rca_s),
        .Cout (w_rca_cout)
    );

    // New nibble enters the sum shift register from the MSB end.
    if (NIBBLES == 1) begin : g_one_nibble
        assign w_sum_next = w_rca_s;
    end else begin : g_multi_nibble
        assign w_sum_next = {w_rca_s, r_sum_sh[WIDTH-1:NIBBLE_W]};
    end

    // Control FSM plus datapath registers: accept, shift-add, hold result.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the operand/sum shift registers are reset too, because a reset
    // mid-operation must discard the partial result completely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh     <= a;
                        r_b_sh     <= w_b_in;
                        r_carry    <= w_cin_in;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    r_a_sh   <= r_a_sh >> NIBBLE_W;
                    r_b_sh   <= r_b_sh >> NIBBLE_W;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_rca_cout;
                    if (r_cnt == LAST_CNT) begin
                        r_sum       <= w_sum_next;
                        r_cout      <= w_rca_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
